// File: rtl/mmio_uart_ctrl_pkg.sv
// Shared definitions for the MMIO UART controller.
//   - Register offsets inside the MMIO window.
//   - TX sequencing FSM state encoding.
//   - Address decode helper that turns a byte address into one-hot register selects.
package mmio_uart_ctrl_pkg;

  localparam logic [31:0] MMIO_STATUS  = 32'h00;
  localparam logic [31:0] MMIO_RX      = 32'h04;
  localparam logic [31:0] MMIO_TX      = 32'h08;
  localparam logic [31:0] MMIO_CYCLE   = 32'h10;
  localparam logic [31:0] MMIO_INSTRET = 32'h14;
  localparam logic [31:0] MMIO_CNT_RST = 32'h18;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

  // One select bit per implemented register; all zero for unmapped addresses.
  typedef struct packed {
    logic status;
    logic rx;
    logic tx;
    logic cycle;
    logic instret;
    logic cnt_rst;
  } mmio_sel_t;

  function automatic mmio_sel_t mmio_decode(input logic [31:0] addr,
                                            input logic [31:0] base);
    mmio_sel_t sel;
    sel.status  = (addr == base + MMIO_STATUS);
    sel.rx      = (addr == base + MMIO_RX);
    sel.tx      = (addr == base + MMIO_TX);
    sel.cycle   = (addr == base + MMIO_CYCLE);
    sel.instret = (addr == base + MMIO_INSTRET);
    sel.cnt_rst = (addr == base + MMIO_CNT_RST);
    return sel;
  endfunction

endpackage

// File: rtl/mmio_uart_ctrl_if.sv
// CPU-side MMIO bus between the EX/WB stage (master) and the controller (slave).
//   mmio_addr_i  : byte address from the ALU result
//   mmio_re_i    : load request
//   mmio_we_i    : store request
//   mmio_wdata_i : store data, low byte of rs2
//   stall_o      : store not accepted this cycle, hold the pipeline
//   mmio_rdata_o : registered load data, valid the cycle after the request
interface mmio_uart_ctrl_if;
  logic [31:0] mmio_addr_i;
  logic        mmio_re_i;
  logic        mmio_we_i;
  logic [7:0]  mmio_wdata_i;
  logic        stall_o;
  logic [31:0] mmio_rdata_o;

  modport master (
    output mmio_addr_i, mmio_re_i, mmio_we_i, mmio_wdata_i,
    input  stall_o, mmio_rdata_o
  );

  modport slave (
    input  mmio_addr_i, mmio_re_i, mmio_we_i, mmio_wdata_i,
    output stall_o, mmio_rdata_o
  );
endinterface

// File: rtl/mmio_tx_fifo.sv
// Synchronous FIFO buffering outgoing UART bytes.
//   clk, rst : clock, asynchronous active-high reset (empties the FIFO)
//   push_i   : write data_i at the tail (ignored when full)
//   pop_i    : drop the head entry (ignored when empty)
//   head_o   : current head entry
//   full_o   : DEPTH entries held
//   empty_o  : no entries held
// DEPTH must be a power of two so the pointers wrap naturally.
module mmio_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rptr_q];

  // NOTE: defaults first, so no path through the block leaves a signal unassigned (that would infer a latch).
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; clearing the pointers and count is what empties the FIFO.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// Memory-mapped UART controller between the core's EX/WB stage and the UART.
//   clk, rst        : clock, asynchronous active-high reset
//   bus             : CPU MMIO bus (slave side), see mmio_uart_ctrl_if
//   inst_exec_i     : one instruction retired this cycle
//   uart_rx_*       : receive handshake, single-byte holding buffer
//   uart_tx_*       : transmit handshake, fed from the TX FIFO by the sequencing FSM
// Registers (offset from BASE_ADDR): 0x00 status, 0x04 rx data, 0x08 tx data,
// 0x10 cycle count, 0x14 instret count, 0x18 counter reset. Others read 0.
module mmio_uart_ctrl
  import mmio_uart_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          TX_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  mmio_uart_ctrl_if.slave        bus,
  input  logic                   inst_exec_i,
  input  logic [7:0]             uart_rx_data_i,
  input  logic                   uart_rx_valid_i,
  output logic                   uart_rx_ready_o,
  output logic [7:0]             uart_tx_data_o,
  output logic                   uart_tx_valid_o,
  input  logic                   uart_tx_ready_i
);

  mmio_sel_t sel;
  assign sel = mmio_decode(bus.mmio_addr_i, BASE_ADDR);

  // ---------------- TX FIFO and store path ----------------
  logic       tx_full, tx_empty, tx_push, tx_pop;
  logic [7:0] tx_head;

  // Full comes from the registered count, so a pop in this same cycle does
  // not release the stall; the store lands on the following cycle.
  assign bus.stall_o = bus.mmio_we_i & sel.tx & tx_full;
  assign tx_push     = bus.mmio_we_i & sel.tx & ~tx_full;

  mmio_tx_fifo #(
    .DEPTH (TX_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push),
    .data_i  (bus.mmio_wdata_i),
    .pop_i   (tx_pop),
    .head_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  // ---------------- TX sequencing FSM ----------------
  tx_state_e  state_q;
  logic [7:0] tx_data_q;
  logic       tx_valid_q;

  // The head moves into the output register whenever the output slot is
  // free (IDLE) or being handed off this cycle (SEND with ready).
  assign tx_pop = ~tx_empty & ((state_q == IDLE) | uart_tx_ready_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!tx_empty) begin
            tx_data_q  <= tx_head;
            tx_valid_q <= 1'b1;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (uart_tx_ready_i) begin
            if (!tx_empty) begin
              tx_data_q <= tx_head;
            end else begin
              tx_valid_q <= 1'b0;
              state_q    <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign uart_tx_data_o  = tx_data_q;
  assign uart_tx_valid_o = tx_valid_q;

  // ---------------- RX holding buffer ----------------
  logic       rx_full_q;
  logic [7:0] rx_data_q;
  logic       rx_cap, rx_pop;

  // Ready is low while full, so capture and pop are mutually exclusive.
  assign rx_cap = uart_rx_valid_i & ~rx_full_q;
  assign rx_pop = bus.mmio_re_i & sel.rx & rx_full_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_full_q <= 1'b0;
      rx_data_q <= '0;
    end else if (rx_cap) begin
      rx_full_q <= 1'b1;
      rx_data_q <= uart_rx_data_i;
    end else if (rx_pop) begin
      rx_full_q <= 1'b0;
    end
  end

  assign uart_rx_ready_o = ~rx_full_q;

  // ---------------- Performance counters ----------------
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] instret_q, instret_d;
  logic        cnt_clr;

  assign cnt_clr   = bus.mmio_we_i & sel.cnt_rst;
  assign cycle_d   = cnt_clr ? '0 : cycle_q + 32'd1;
  assign instret_d = cnt_clr ? '0 : instret_q + {31'd0, inst_exec_i};

  // ---------------- Load path ----------------
  // Counters are read from the _q side, i.e. before this cycle's update.
  logic [31:0] rdata_d, rdata_q;

  always_comb begin
    rdata_d = '0;
    if (bus.mmio_re_i) begin
      if (sel.status)       rdata_d = {30'b0, rx_full_q, ~tx_full};
      else if (sel.rx)      rdata_d = {24'b0, rx_data_q};
      else if (sel.cycle)   rdata_d = cycle_q;
      else if (sel.instret) rdata_d = instret_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q   <= '0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      rdata_q   <= rdata_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign bus.mmio_rdata_o = rdata_q;

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Self-checking bench for mmio_uart_ctrl: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// queue-based behavioural model.
module tb_mmio_uart_ctrl;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inst_exec;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  mmio_uart_ctrl_if bus_if ();

  mmio_uart_ctrl #(
    .BASE_ADDR (BASE),
    .TX_DEPTH  (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus_if),
    .inst_exec_i     (inst_exec),
    .uart_rx_data_i  (rx_data),
    .uart_rx_valid_i (rx_valid),
    .uart_rx_ready_o (rx_ready),
    .uart_tx_data_o  (tx_data),
    .uart_tx_valid_o (tx_valid),
    .uart_tx_ready_i (tx_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_fifo[$];   // bytes accepted but not yet presented
  logic        m_tx_valid;
  logic [7:0]  m_tx_data;
  logic        m_rx_full;
  logic [7:0]  m_rx_data;
  logic [31:0] m_cycle, m_instret, m_rdata;
  logic        force_cyc = 1'b0;

  function automatic void model_reset();
    m_fifo.delete();
    m_tx_valid = 1'b0;
    m_tx_data  = 8'h00;
    m_rx_full  = 1'b0;
    m_rx_data  = 8'h00;
    m_cycle    = 32'h0;
    m_instret  = 32'h0;
    m_rdata    = 32'h0;
  endfunction

  function automatic logic model_stall();
    return bus_if.mmio_we_i && (bus_if.mmio_addr_i == BASE + 32'h08) && (m_fifo.size() == DEPTH);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a == BASE + 32'h00) return {30'b0, m_rx_full, m_fifo.size() != DEPTH};
    if (a == BASE + 32'h04) return {24'b0, m_rx_data};
    if (a == BASE + 32'h10) return m_cycle;
    if (a == BASE + 32'h14) return m_instret;
    return 32'h0;
  endfunction

  function automatic void model_step();
    logic [31:0] a;
    logic        rx_pop, push, clr, out_free;
    a        = bus_if.mmio_addr_i;
    rx_pop   = bus_if.mmio_re_i && (a == BASE + 32'h04) && m_rx_full;
    push     = bus_if.mmio_we_i && (a == BASE + 32'h08) && !model_stall();
    clr      = bus_if.mmio_we_i && (a == BASE + 32'h18);
    out_free = !m_tx_valid || tx_ready;
    m_rdata  = bus_if.mmio_re_i ? model_read(a) : 32'h0;
    // transmit side: handed-off byte leaves, next head (if any) takes its place
    if (m_tx_valid && tx_ready) m_tx_valid = 1'b0;
    if (out_free && m_fifo.size() > 0) begin
      m_tx_data  = m_fifo.pop_front();
      m_tx_valid = 1'b1;
    end
    if (push) m_fifo.push_back(bus_if.mmio_wdata_i);
    // receive side
    if (rx_valid && !m_rx_full) begin
      m_rx_data = rx_data;
      m_rx_full = 1'b1;
    end else if (rx_pop) begin
      m_rx_full = 1'b0;
    end
    // counters
    m_cycle   = force_cyc ? 32'hFFFF_FFFF : (clr ? 32'h0 : m_cycle + 32'd1);
    m_instret = clr ? 32'h0 : m_instret + {31'd0, inst_exec};
  endfunction

  // Compare process: outputs settle mid-cycle; inputs are changed just after posedge.
  always @(negedge clk) begin
    if (rst) model_reset();
    check("rdata", bus_if.mmio_rdata_o, m_rdata);
    check("tx_valid", {31'd0, tx_valid}, {31'd0, m_tx_valid});
    if (m_tx_valid) check("tx_data", {24'd0, tx_data}, {24'd0, m_tx_data});
    check("rx_ready", {31'd0, rx_ready}, {31'd0, !m_rx_full});
    check("stall", {31'd0, bus_if.stall_o}, {31'd0, model_stall()});
    if (!rst) model_step();
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_if.mmio_addr_i  = 32'h0;
    bus_if.mmio_re_i    = 1'b0;
    bus_if.mmio_we_i    = 1'b0;
    bus_if.mmio_wdata_i = 8'h00;
    inst_exec = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
  endtask

  task automatic load(input logic [31:0] off);
    bus_if.mmio_re_i   = 1'b1;
    bus_if.mmio_we_i   = 1'b0;
    bus_if.mmio_addr_i = BASE + off;
  endtask

  task automatic store(input logic [31:0] off, input logic [7:0] d);
    bus_if.mmio_re_i    = 1'b0;
    bus_if.mmio_we_i    = 1'b1;
    bus_if.mmio_addr_i  = BASE + off;
    bus_if.mmio_wdata_i = d;
  endtask

  logic [31:0] addr_pool [9];

  initial begin
    idle();
    tx_ready = 1'b0;
    model_reset();
    repeat (3) step();
    check("reset rdata", bus_if.mmio_rdata_o, 32'h0);
    check("reset tx_valid", {31'd0, tx_valid}, 32'h0);
    check("reset tx_data", {24'd0, tx_data}, 32'h0);
    check("reset rx_ready", {31'd0, rx_ready}, 32'h1);
    rst = 1'b0;

    // status after reset
    load(32'h00);
    step();
    idle();
    check("status after reset", bus_if.mmio_rdata_o, 32'h1);

    // single byte, ready low: presented two edges after the store
    store(32'h08, 8'h41);
    step();
    idle();
    step();
    check("tx_valid 0x41", {31'd0, tx_valid}, 32'h1);
    check("tx_data 0x41", {24'd0, tx_data}, 32'h41);
    repeat (3) step();
    check("tx_data 0x41 stable", {24'd0, tx_data}, 32'h41);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    check("tx_valid drop", {31'd0, tx_valid}, 32'h0);

    // five stores fit (one presented + four queued), sixth stalls
    for (int i = 1; i <= 5; i++) begin
      store(32'h08, 8'(i));
      #1;
      check("no stall on store", {31'd0, bus_if.stall_o}, 32'h0);
      step();
    end
    store(32'h08, 8'h06);
    #1;
    check("stall sixth store", {31'd0, bus_if.stall_o}, 32'h1);
    step();
    check("stall held", {31'd0, bus_if.stall_o}, 32'h1);
    tx_ready = 1'b1;
    #1;
    check("stall during pop", {31'd0, bus_if.stall_o}, 32'h1);
    step();
    tx_ready = 1'b0;
    #1;
    check("stall released", {31'd0, bus_if.stall_o}, 32'h0);
    check("tx_data after pulse", {24'd0, tx_data}, 32'h02);
    step();
    idle();
    tx_ready = 1'b1;
    for (int b = 3; b <= 6; b++) begin
      step();
      check("burst byte", {24'd0, tx_data}, 32'(b));
    end
    step();
    check("burst end valid", {31'd0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // RX buffer
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    step();
    check("rx_ready low when full", {31'd0, rx_ready}, 32'h0);
    rx_data = 8'hA5;  // must be ignored while full
    load(32'h00);
    step();
    rx_valid = 1'b0;
    check("status rx full", bus_if.mmio_rdata_o, 32'h3);
    load(32'h04);
    step();
    check("rx read", bus_if.mmio_rdata_o, 32'h5A);
    check("rx_ready after pop", {31'd0, rx_ready}, 32'h1);
    step();
    idle();
    check("rx stale read", bus_if.mmio_rdata_o, 32'h5A);

    // counters
    for (int i = 0; i < 100; i++) begin
      inst_exec = i[0];
      if (i == 50) load(32'h14);
      else if (i == 60) load(32'h10);
      else begin bus_if.mmio_re_i = 1'b0; end
      step();
    end
    idle();
    store(32'h18, 8'hFF);
    step();
    idle();
    step();
    load(32'h10);
    step();
    check("cycle after clear", bus_if.mmio_rdata_o, 32'h1);
    load(32'h14);
    step();
    check("instret after clear", bus_if.mmio_rdata_o, 32'h0);
    idle();

    // cycle counter wrap
    force dut.cycle_d = 32'hFFFF_FFFF;
    force_cyc = 1'b1;
    step();
    release dut.cycle_d;
    force_cyc = 1'b0;
    load(32'h10);
    step();
    check("cycle at max", bus_if.mmio_rdata_o, 32'hFFFF_FFFF);
    step();
    check("cycle wrapped", bus_if.mmio_rdata_o, 32'h0);
    idle();

    // reset in the middle of a transfer
    rx_valid = 1'b1;
    rx_data  = 8'h33;
    step();
    rx_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      store(32'h08, 8'h11 * 8'(i + 1));
      step();
    end
    idle();
    step();
    check("in SEND before reset", {31'd0, tx_valid}, 32'h1);
    rst = 1'b1;
    #1;
    check("async reset tx_valid", {31'd0, tx_valid}, 32'h0);
    check("async reset rx_ready", {31'd0, rx_ready}, 32'h1);
    step();
    step();
    rst = 1'b0;
    tx_ready = 1'b1;
    load(32'h00);
    step();
    check("status after mid reset", bus_if.mmio_rdata_o, 32'h1);
    load(32'h04);
    step();
    check("rx cleared by reset", bus_if.mmio_rdata_o, 32'h0);
    idle();
    repeat (4) step();
    check("no stale tx", {31'd0, tx_valid}, 32'h0);

    // randomized traffic
    addr_pool = '{BASE + 32'h00, BASE + 32'h04, BASE + 32'h08, BASE + 32'h0C,
                  BASE + 32'h10, BASE + 32'h14, BASE + 32'h18, BASE + 32'h1C,
                  32'h0000_0008};
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      a = addr_pool[$urandom_range(0, 8)];
      if (a == BASE + 32'h18 && $urandom_range(0, 7) != 0) a = BASE + 32'h08;
      bus_if.mmio_addr_i  = a;
      bus_if.mmio_re_i    = 1'($urandom_range(0, 1));
      bus_if.mmio_we_i    = ($urandom_range(0, 2) == 0);
      bus_if.mmio_wdata_i = 8'($urandom);
      inst_exec = 1'($urandom_range(0, 1));
      rx_valid  = ($urandom_range(0, 3) == 0);
      rx_data   = 8'($urandom);
      tx_ready  = ($urandom_range(0, 2) != 0);
      step();
    end
    idle();
    tx_ready = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
